// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: barrel-aligns raw 10-bit deserializer words on control tokens,
// then decodes each symbol into a pixel byte (DE=1) or control pair (DE=0).
module tmds_channel_decoder #(
    parameter int unsigned CTRL_RUN     = 8,
    parameter int unsigned HUNT_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT = 4096
) (
    input  logic       i_pix_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_tmds_word,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_de,
    output logic       o_aligned,
    output logic [3:0] o_offset,
    output logic       o_bitslip
);

    localparam int unsigned RunW  = (CTRL_RUN > 1) ? $clog2(CTRL_RUN) : 1;
    localparam int unsigned HuntW = (HUNT_TIMEOUT > 1) ? $clog2(HUNT_TIMEOUT) : 1;
    localparam int unsigned SilW  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [RunW-1:0]  RunLast  = RunW'(CTRL_RUN - 1);
    localparam logic [HuntW-1:0] HuntLast = HuntW'(HUNT_TIMEOUT - 1);
    localparam logic [SilW-1:0]  SilLast  = SilW'(LOCK_TIMEOUT - 1);

    typedef enum logic {
        StHunt,
        StLocked
    } state_e;

    state_e           state_q, state_d;
    logic [9:0]       r_prev_q;
    logic [3:0]       offset_q, offset_d;
    logic [RunW-1:0]  run_q, run_d;
    logic [HuntW-1:0] hunt_q, hunt_d;
    logic [SilW-1:0]  sil_q, sil_d;
    logic             bitslip_q, bitslip_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             de_q, de_d;

    // Offset 9 reaches bit 18 at most, so the newest word's MSB is never part of the window.
    logic [18:0] pair;
    logic [4:0]  base;
    logic [9:0]  window;

    assign pair   = {i_tmds_word[8:0], r_prev_q};
    assign base   = {1'b0, offset_q};
    assign window = pair[base +: 10];

    logic       is_token;
    logic [1:0] tok_bits;

    always_comb begin
        is_token = 1'b1;
        tok_bits = 2'b00;
        case (window)
            10'h354: tok_bits = 2'b00;
            10'h0AB: tok_bits = 2'b01;
            10'h154: tok_bits = 2'b10;
            10'h2AB: tok_bits = 2'b11;
            default: is_token = 1'b0;
        endcase
    end

    logic [7:0] t_byte;
    logic [7:0] q_byte;

    always_comb begin
        t_byte    = window[9] ? ~window[7:0] : window[7:0];
        q_byte    = 8'h00;
        q_byte[0] = t_byte[0];
        for (int i = 1; i < 8; i++) begin
            q_byte[i] = window[8] ? (t_byte[i] ^ t_byte[i-1]) : ~(t_byte[i] ^ t_byte[i-1]);
        end
    end

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        run_d     = run_q;
        hunt_d    = hunt_q;
        sil_d     = sil_q;
        bitslip_d = 1'b0;
        unique case (state_q)
            StHunt: begin
                if (!is_token) begin
                    run_d = '0;
                end else if (run_q != RunLast) begin
                    run_d = run_q + 1'b1;
                end
                if (hunt_q != HuntLast) begin
                    hunt_d = hunt_q + 1'b1;
                end
                // A completed run wins over a coincident timeout.
                if (is_token && (run_q == RunLast)) begin
                    state_d = StLocked;
                    run_d   = '0;
                    hunt_d  = '0;
                    sil_d   = '0;
                end else if (hunt_q == HuntLast) begin
                    offset_d  = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                    bitslip_d = 1'b1;
                    hunt_d    = '0;
                    run_d     = '0;
                end
            end
            StLocked: begin
                if (is_token) begin
                    sil_d = '0;
                end else if (sil_q == SilLast) begin
                    state_d = StHunt;
                    sil_d   = '0;
                    run_d   = '0;
                    hunt_d  = '0;
                end else begin
                    sil_d = sil_q + 1'b1;
                end
            end
        endcase
    end

    // Outputs follow the next state so the locking token and the lock-loss edge are both visible.
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        de_d   = 1'b0;
        if (state_d != StLocked) begin
            data_d = 8'h00;
            ctrl_d = 2'b00;
        end else if (is_token) begin
            ctrl_d = tok_bits;
        end else begin
            de_d   = 1'b1;
            data_d = q_byte;
        end
    end

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StHunt;
            r_prev_q  <= 10'h000;
            offset_q  <= 4'd0;
            run_q     <= '0;
            hunt_q    <= '0;
            sil_q     <= '0;
            bitslip_q <= 1'b0;
            data_q    <= 8'h00;
            ctrl_q    <= 2'b00;
            de_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_prev_q  <= i_tmds_word;
            offset_q  <= offset_d;
            run_q     <= run_d;
            hunt_q    <= hunt_d;
            sil_q     <= sil_d;
            bitslip_q <= bitslip_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            de_q      <= de_d;
        end
    end

    assign o_data    = data_q;
    assign o_ctrl    = ctrl_q;
    assign o_de      = de_q;
    assign o_aligned = (state_q == StLocked);
    assign o_offset  = offset_q;
    assign o_bitslip = bitslip_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: alignment hunt, lock/loss, offset wrap and
// symbol decode, with decode results checked through an expected-value queue.
module tb_tmds_channel_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] word;
    logic [7:0] o_data;
    logic [1:0] o_ctrl;
    logic       o_de;
    logic       o_aligned;
    logic [3:0] o_offset;
    logic       o_bitslip;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       de;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    tmds_channel_decoder #(
        .CTRL_RUN    (8),
        .HUNT_TIMEOUT(64),
        .LOCK_TIMEOUT(4096)
    ) dut (
        .i_pix_clk  (clk),
        .i_rst_n    (rst_n),
        .i_tmds_word(word),
        .o_data     (o_data),
        .o_ctrl     (o_ctrl),
        .o_de       (o_de),
        .o_aligned  (o_aligned),
        .o_offset   (o_offset),
        .o_bitslip  (o_bitslip)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        word  = 10'h000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Word carrying symbol cur_sym so that it is seen whole at window offset k.
    function automatic logic [9:0] rot_word(input logic [9:0] cur_sym, input logic [9:0] prev_sym,
                                            input int k);
        logic [19:0] pr;
        pr = {cur_sym, prev_sym};
        pr = pr >> (10 - k);
        return pr[9:0];
    endfunction

    function automatic logic [9:0] period_sym(input int n, input logic [9:0] dat);
        if (n < 0) return 10'h100;
        return ((n % 40) < 24) ? 10'h354 : dat;
    endfunction

    function automatic logic [2:0] tok(input logic [9:0] w);
        case (w)
            10'h354: return 3'b100;
            10'h0AB: return 3'b101;
            10'h154: return 3'b110;
            10'h2AB: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] w);
        logic [7:0] t;
        logic [7:0] q;
        t    = w[9] ? ~w[7:0] : w[7:0];
        q    = 8'h00;
        q[0] = t[0];
        for (int i = 1; i < 8; i++) q[i] = w[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        return q;
    endfunction

    task automatic lock_offset0();
        word = 10'h354;
        for (int t = 0; t < 40 && o_aligned !== 1'b1; t++) tick();
        checks++;
        if (o_aligned !== 1'b1) begin
            errors++;
            $display("FAIL lock_wait: o_aligned=%b want 1", o_aligned);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            word = 10'($urandom_range(0, 1023));
            tick();
            checks++;
            if ({o_data, o_ctrl, o_de, o_aligned, o_offset, o_bitslip} !== 17'd0) begin
                errors++;
                $display("FAIL reset_outputs: got %h want 0",
                         {o_data, o_ctrl, o_de, o_aligned, o_offset, o_bitslip});
            end
        end
        rst_n = 1'b1;
        word  = 10'h000;
        for (int i = 1; i <= 100; i++) begin
            tick();
            checks++;
            if (o_aligned !== 1'b0 || o_bitslip !== (i == 64) ||
                o_offset !== ((i >= 64) ? 4'd1 : 4'd0)) begin
                errors++;
                $display("FAIL hunt_step cyc %0d: aligned=%b slip=%b off=%0d want 0 %b %0d", i,
                         o_aligned, o_bitslip, o_offset, (i == 64), (i >= 64) ? 1 : 0);
            end
        end
    endtask

    task automatic test_aligned_lock();
        int slips = 0;
        apply_reset();
        word = 10'h354;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (o_bitslip === 1'b1) slips++;
            checks++;
            if (o_aligned !== (i >= 9)) begin
                errors++;
                $display("FAIL aligned_rise cyc %0d: aligned=%b want %b", i, o_aligned, (i >= 9));
            end
            if (i == 9) begin
                checks++;
                if (o_ctrl !== 2'b00 || o_de !== 1'b0) begin
                    errors++;
                    $display("FAIL first_locked_sym: ctrl=%b de=%b want 00 0", o_ctrl, o_de);
                end
            end
        end
        checks++;
        if (slips != 0 || o_offset !== 4'd0) begin
            errors++;
            $display("FAIL aligned_offset: slips=%0d off=%0d want 0 0", slips, o_offset);
        end
    endtask

    task automatic test_shifted_lock();
        int slip_at[$];
        int n = 0;
        int de_cnt = 0;
        int bad = 0;
        int want;
        int got;
        apply_reset();
        while (n < 400 && o_aligned !== 1'b1) begin
            word = rot_word(period_sym(n, 10'h100), period_sym(n - 1, 10'h100), 3);
            tick();
            n++;
            if (o_bitslip === 1'b1) slip_at.push_back(n);
        end
        checks++;
        if (o_aligned !== 1'b1 || o_offset !== 4'd3 || slip_at.size() != 3) begin
            errors++;
            $display("FAIL shifted_lock: aligned=%b off=%0d slips=%0d want 1 3 3", o_aligned,
                     o_offset, slip_at.size());
        end
        for (int i = 0; i < 3; i++) begin
            want = 64 * (i + 1);
            got  = (i < slip_at.size()) ? slip_at[i] : -1;
            checks++;
            if (got != want) begin
                errors++;
                $display("FAIL slip_time %0d: cyc=%0d want %0d", i, got, want);
            end
        end
        for (int i = 0; i < 40; i++) begin
            word = rot_word(period_sym(n, 10'h100), period_sym(n - 1, 10'h100), 3);
            tick();
            n++;
            if (o_de === 1'b1) begin
                de_cnt++;
                if (o_data !== 8'h00) bad++;
            end
            if (o_aligned !== 1'b1) bad++;
        end
        checks++;
        if (de_cnt != 16 || bad != 0) begin
            errors++;
            $display("FAIL shifted_period: de_cycles=%0d bad=%0d want 16 0", de_cnt, bad);
        end
    endtask

    task automatic test_decode();
        logic [9:0] stim[6];
        exp_t       tab[6];
        exp_t       e;
        stim = '{10'h100, 10'h1FF, 10'h2FF, 10'h0AB, 10'h154, 10'h2AB};
        tab  = '{'{8'h00, 2'b00, 1'b1}, '{8'h01, 2'b00, 1'b1}, '{8'hFE, 2'b00, 1'b1},
                 '{8'hFE, 2'b01, 1'b0}, '{8'hFE, 2'b10, 1'b0}, '{8'hFE, 2'b11, 1'b0}};
        apply_reset();
        lock_offset0();
        exp_q.delete();
        for (int i = 0; i <= 6; i++) begin
            word = (i < 6) ? stim[i] : 10'h354;
            if (i < 6) exp_q.push_back(tab[i]);
            tick();
            if (i >= 1) begin
                e = exp_q.pop_front();
                checks++;
                if ({o_data, o_ctrl, o_de} !== e) begin
                    errors++;
                    $display("FAIL decode %0d: data=%h ctrl=%b de=%b want %h %b %b", i - 1,
                             o_data, o_ctrl, o_de, e.data, e.ctrl, e.de);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL decode_drain: left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] toks[4];
        logic [9:0] w;
        logic [2:0] tk;
        logic [7:0] data_hold = 8'h00;
        logic [1:0] ctrl_hold = 2'b00;
        exp_t       e;
        int         bad = 0;
        toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        apply_reset();
        lock_offset0();
        exp_q.delete();
        for (int i = 0; i <= 48; i++) begin
            if (i < 48) begin
                if ($urandom_range(0, 3) == 0) w = toks[$urandom_range(0, 3)];
                else w = 10'($urandom_range(0, 1023));
                tk = tok(w);
                if (tk[2]) begin
                    ctrl_hold = tk[1:0];
                    exp_q.push_back('{data_hold, ctrl_hold, 1'b0});
                end else begin
                    data_hold = dec(w);
                    exp_q.push_back('{data_hold, ctrl_hold, 1'b1});
                end
                word = w;
            end else begin
                word = 10'h354;
            end
            tick();
            if (i >= 1) begin
                e = exp_q.pop_front();
                checks++;
                if ({o_data, o_ctrl, o_de} !== e) begin
                    bad++;
                    errors++;
                    $display("FAIL b2b %0d: data=%h ctrl=%b de=%b want %h %b %b", i - 1, o_data,
                             o_ctrl, o_de, e.data, e.ctrl, e.de);
                end
            end
        end
    endtask

    task automatic test_lock_loss();
        int fall_t = 0;
        int relock_t = 0;
        int slips = 0;
        apply_reset();
        lock_offset0();
        word = 10'h100;
        // First driven word reaches the window one edge later: 4096 silent windows end at 4097.
        for (int t = 1; t <= 4200 && fall_t == 0; t++) begin
            tick();
            if (o_aligned !== 1'b1) fall_t = t;
        end
        checks++;
        if (fall_t != 4097 || o_offset !== 4'd0 || o_de !== 1'b0 || o_ctrl !== 2'b00) begin
            errors++;
            $display("FAIL lock_loss: fall=%0d off=%0d de=%b ctrl=%b want 4097 0 0 00", fall_t,
                     o_offset, o_de, o_ctrl);
        end
        word = 10'h354;
        for (int t = 1; t <= 100 && relock_t == 0; t++) begin
            tick();
            if (o_bitslip === 1'b1) slips++;
            if (o_aligned === 1'b1) relock_t = t;
        end
        checks++;
        if (relock_t != 9 || slips != 0 || o_offset !== 4'd0) begin
            errors++;
            $display("FAIL relock: cyc=%0d slips=%0d off=%0d want 9 0 0", relock_t, slips,
                     o_offset);
        end
    endtask

    task automatic test_offset_wrap();
        int         slips = 0;
        int         dropped = 0;
        int         slip_t = 0;
        int         lock_t = 0;
        logic [3:0] off_at_slip = 4'hF;
        logic [9:0] prev_sym = 10'h354;
        apply_reset();
        word = rot_word(10'h354, 10'h354, 9);
        for (int t = 0; t < 800 && o_aligned !== 1'b1; t++) begin
            tick();
            if (o_bitslip === 1'b1) slips++;
        end
        checks++;
        if (o_aligned !== 1'b1 || slips != 9 || o_offset !== 4'd9) begin
            errors++;
            $display("FAIL lock_off9: aligned=%b slips=%0d off=%0d want 1 9 9", o_aligned, slips,
                     o_offset);
        end
        for (int t = 0; t < 4200 && dropped == 0; t++) begin
            word     = rot_word(10'h100, prev_sym, 9);
            prev_sym = 10'h100;
            tick();
            if (o_aligned !== 1'b1) dropped = 1;
        end
        checks++;
        if (dropped != 1 || o_offset !== 4'd9) begin
            errors++;
            $display("FAIL drop_off9: dropped=%0d off=%0d want 1 9", dropped, o_offset);
        end
        word = 10'h354;
        for (int j = 1; j <= 200 && lock_t == 0; j++) begin
            tick();
            if (o_bitslip === 1'b1 && slip_t == 0) begin
                slip_t      = j;
                off_at_slip = o_offset;
            end
            if (o_aligned === 1'b1) lock_t = j;
        end
        checks++;
        if (slip_t != 64 || off_at_slip !== 4'd0) begin
            errors++;
            $display("FAIL offset_wrap: slip_cyc=%0d off=%0d want 64 0", slip_t, off_at_slip);
        end
        checks++;
        if (lock_t != 72 || o_offset !== 4'd0) begin
            errors++;
            $display("FAIL relock_off0: cyc=%0d off=%0d want 72 0", lock_t, o_offset);
        end
    endtask

    task automatic test_reset_mid_lock();
        int n = 0;
        int bad = 0;
        apply_reset();
        while (n < 800 && !(o_aligned === 1'b1 && o_de === 1'b1)) begin
            word = rot_word(period_sym(n, 10'h1FF), period_sym(n - 1, 10'h1FF), 5);
            tick();
            n++;
        end
        checks++;
        if (o_aligned !== 1'b1 || o_de !== 1'b1 || o_data !== 8'h01 || o_offset !== 4'd5) begin
            errors++;
            $display("FAIL midlock_setup: aligned=%b de=%b data=%h off=%0d want 1 1 01 5",
                     o_aligned, o_de, o_data, o_offset);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_data, o_ctrl, o_de, o_aligned, o_offset, o_bitslip} !== 17'd0) begin
            errors++;
            $display("FAIL async_clear: got %h want 0",
                     {o_data, o_ctrl, o_de, o_aligned, o_offset, o_bitslip});
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            word = rot_word(period_sym(n, 10'h1FF), period_sym(n - 1, 10'h1FF), 5);
            tick();
            n++;
            if (o_de !== 1'b0 || o_aligned !== 1'b0 || o_data !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: bad_cycles=%0d want 0", bad);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        word  = 10'h000;
        test_reset();
        test_aligned_lock();
        test_shifted_lock();
        test_decode();
        test_back_to_back();
        test_lock_loss();
        test_offset_wrap();
        test_reset_mid_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

- Receive-side counterpart to the HDMI transmit path; one instance per TMDS channel.
- Takes 10-bit parallel words from the channel deserializer in the pixel-clock domain.
- Finds the 10-bit symbol boundary using an internal barrel aligner that hunts for control tokens.
- Once aligned, decodes each symbol into video data (8 bits, DE=1) or control bits (2 bits, DE=0) for the sink-side display timing recovery and loopback checker.

## Interface

Parameters:
- CTRL_RUN, 8: consecutive control tokens needed at the current offset to declare lock.
- HUNT_TIMEOUT, 64: cycles spent at one offset before advancing to the next.
- LOCK_TIMEOUT, 4096: cycles without any control token before lock is dropped.

Ports:
- i_pix_clk  in  1  pixel clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_tmds_word  in  10  raw deserialized word; bit 0 is the earliest serial bit.
- o_data  out  8  decoded pixel byte.
- o_ctrl  out  2  decoded control bits {C1,C0}.
- o_de  out  1  1 = o_data valid this cycle; 0 = blanking/control.
- o_aligned  out  1  1 while in LOCKED.
- o_offset  out  4  current window offset, range 0..9.
- o_bitslip  out  1  one-cycle pulse each time the offset advances.

## Operation

Aligner:
- r_prev registers i_tmds_word every cycle.
- The 10-bit window is bits [o_offset+9 : o_offset] of {i_tmds_word, r_prev}.
- Offset 0 gives the window r_prev.

Control tokens (window value, MSB = bit 9):
- 0x354 -> 00
- 0x0AB -> 01
- 0x154 -> 10
- 0x2AB -> 11
- Any other window value is a data symbol.

Data decode:
- If d[9] = 1, invert d[7:0] first to get t.
- q[0] = t[0].
- For i = 1..7: q[i] = t[i] ^ t[i-1] when d[8] = 1, otherwise ~(t[i] ^ t[i-1]).

State machine (2 states):
- **HUNT**
  - run_cnt: +1 on a control token, cleared on a data symbol.
  - hunt_cnt: +1 every cycle.
  - If the run reaches CTRL_RUN, go to LOCKED on the same edge; this takes priority over the timeout.
  - Otherwise, when hunt_cnt = HUNT_TIMEOUT-1: offset <= (offset = 9) ? 0 : offset+1, pulse o_bitslip, clear hunt_cnt and run_cnt.
  - The new offset takes effect on the window from the next cycle.
- **LOCKED**
  - silence_cnt clears on every control token and increments otherwise.
  - When silence_cnt reaches LOCK_TIMEOUT-1 without a token, go to HUNT. Offset is kept; all counters are cleared.
  - The offset never changes while LOCKED.

Output gating:
- The output register is gated by the next state.
- When the next state is not LOCKED: o_de = 0, o_data = 0x00, o_ctrl = 00.
- When LOCKED and the window is a token: o_de = 0, o_ctrl = token bits, o_data holds its last value.
- When LOCKED and the window is data: o_de = 1, o_data = q, o_ctrl holds.

Counter widths are $clog2 of their parameter; counters saturate at their terminal value and never wrap.

## Timing

- Reset (asynchronous assert, synchronous release): state HUNT, offset 0, all counters 0, r_prev 0, all outputs 0.
- Latency at offset 0: a word sampled at edge n appears on o_data/o_ctrl/o_de after edge n+1, i.e. 2 cycles.
- Non-zero offsets mix words n and n+1, still with 2-cycle latency.
- The symbol that completes CTRL_RUN is the first output with o_aligned = 1: o_de = 0 and o_ctrl = its bits.
- o_bitslip is high for exactly one cycle per offset change; o_offset updates on that same edge.
- Losing lock: o_aligned, o_de and o_ctrl drop to 0 on the edge that enters HUNT.
- Reset asserted mid-lock: everything clears immediately; no partial symbol is emitted after release.

## Test plan

1. **Reset:** hold i_rst_n = 0 with random i_tmds_word.
   - Required: all outputs 0. Then release and drive 0x000 for 100 cycles.
   - Required: o_aligned = 0, o_offset steps 0 -> 1 with a bitslip pulse at cycle 64.
2. **Aligned lock:** drive 0x354 continuously at offset 0.
   - Required: o_aligned rises after edge 9 (8 tokens plus r_prev), o_offset = 0, zero bitslip pulses, o_ctrl = 00.
3. **Shifted lock:** stream of 24 × 0x354 then 16 × 0x100, repeating, rotated so symbols start at bit 3.
   - Required: exactly 3 bitslip pulses (cycles 64, 128, 192), lock with o_offset = 3.
   - Required: afterwards, 16 cycles of o_de = 1 with o_data = 0x00 per period.
4. **Decode:** locked at offset 0, feed 0x100, 0x1FF, 0x2FF, 0x0AB, 0x154, 0x2AB.
   - Required, 2 cycles later: 0x00/de = 1, 0x01/de = 1, 0xFE/de = 1, ctrl 01, 10, 11 with de = 0.
5. **Lock loss:** locked, then only 0x100 for 4096 cycles.
   - Required: o_aligned falls on cycle 4096 and o_offset is unchanged.
   - Then restore tokens: relock after 8 tokens with no bitslip.
6. **Offset wrap:** stream aligned at offset 9 only.
   - Required: lock at offset 9 after 9 bitslips.
   - Then force a relock at offset 0: offset wraps 9 -> 0 after 64 cycles in HUNT.
